dma_priority_arbiter: RTL and testbench
=======================================

Name: dma_priority_arbiter

Overview:
- Channel priority resolver for the 4-channel DMA controller; sits between the DREQ pins and the timing-control FSM.
- Samples DREQ[3:0], applies the mask, polarity and priority mode from the command and mask registers, and locks one winning channel per service cycle.
- Drives the one-hot VALID_DREQ to the timing FSM and DACK to the pins.
- Requests the bus (HRQ) and releases it when the timing FSM reports service done or EOP.

Parameters:
- NCH, 4, number of DMA channels (fixed at 4 for 8237A compatibility; the logic is written generic).
- SYNC_STAGES, 1, number of DREQ input register stages ahead of arbitration (1 or 2).

Ports:
- CLK  input  1  system clock.
- RESET_N  input  1  synchronous active-low reset.
- DREQ  input  NCH  raw channel requests; polarity selected by dreq_low.
- mask  input  NCH  per-channel mask; 1 = channel ignored.
- ctrl_disable  input  1  commandReg[2]; 1 = no new grants.
- rotate_en  input  1  commandReg[4]; 0 = fixed priority (ch0 highest), 1 = rotating.
- dreq_low  input  1  commandReg[6]; 1 = DREQ active low.
- dack_high  input  1  commandReg[7]; 1 = DACK active high.
- HLDA  input  1  hold acknowledge from the CPU.
- dack_window  input  1  validDACK from the timing FSM (S1..S3).
- service_done  input  1  one-cycle pulse from the timing FSM at the end of S4.
- EOP_N  input  1  end-of-process, active low.
- VALID_DREQ  output  NCH  one-hot locked channel to the timing FSM.
- DACK  output  NCH  acknowledge pins, polarity per dack_high.
- hrq  output  1  hold request.
- active_ch  output  2  encoded locked channel.
- busy  output  1  high while a channel is locked.

Behaviour:
- Request input:
  - req_s = registered (DREQ XOR {NCH{dreq_low}}) through SYNC_STAGES flops.
  - eligible = req_s & ~mask.
- Reset (RESET_N = 0 at a CLK edge):
  - state = IDLE; VALID_DREQ = 0; hrq = 0; busy = 0; active_ch = 0.
  - Priority pointer = 0, so ch0 is highest.
  - DACK = all inactive, i.e. {NCH{~dack_high}} evaluated combinationally.
  - Reset mid-service aborts immediately; no completion is reported.
- States (one-hot): IDLE, ARB, HOLD, SERVE, RELEASE.
- IDLE:
  - Go to ARB if eligible != 0 and ctrl_disable = 0.
  - Otherwise stay in IDLE.
- ARB (1 cycle):
  - Pick the winner: highest-priority set bit of eligible, searching circularly from the priority pointer.
  - Latch the winner into VALID_DREQ and active_ch; set busy = 1; go to HOLD.
  - If eligible dropped to 0 during this cycle, return to IDLE with no latch.
- HOLD:
  - hrq = 1; the winner stays locked even if a higher-priority request appears.
  - Go to SERVE when HLDA = 1.
  - If the locked channel's request deasserts before HLDA, the grant holds anyway; the latched request is serviced.
- SERVE:
  - hrq = 1.
  - DACK[active_ch] is active while dack_window = 1; all other DACK bits stay inactive.
  - Go to RELEASE on service_done = 1, or on EOP_N = 0 (takes effect the next cycle).
  - Simultaneous service_done and EOP_N low is treated as a single completion.
- RELEASE (1 cycle):
  - hrq = 0; VALID_DREQ = 0; busy = 0; all DACK inactive; go to IDLE.
  - Rotating mode: pointer = (active_ch + 1) mod NCH, so the serviced channel becomes lowest priority.
  - Fixed mode: pointer held at 0.
- rotate_en changes take effect at the next ARB; a 1->0 change also forces the pointer to 0 at the next RELEASE.
- mask or ctrl_disable asserted while in HOLD/SERVE does not abort the current service; it only affects the next ARB.
- Latency: DREQ edge to hrq = SYNC_STAGES + 2 cycles (sync, IDLE->ARB, ARB->HOLD).
- HLDA low while in SERVE: hold in SERVE with DACK inactive, and keep hrq = 1.

Optional Feature:
- Macro: DMA_SW_REQUEST_EN.
- Defined:
  - Adds input sw_req [NCH-1:0] (request register) and output sw_req_clr [NCH-1:0].
  - eligible = (req_s | sw_req) & ~mask_eff, where mask_eff = mask & ~sw_req; software requests are unmaskable, per 8237A.
  - In RELEASE, sw_req_clr[active_ch] pulses 1 for one cycle if the service was for a software request.
- Undefined: no sw_req / sw_req_clr ports; eligibility uses DREQ only.

Test Plan:
- Fixed priority, SYNC_STAGES = 1, DREQ = 4'b1010, mask = 0, rotate_en = 0 -> hrq high 3 cycles later; VALID_DREQ = 4'b0010; after HLDA and dack_window, DACK[1] is the only active bit.
- Rotating: DREQ = 4'b1111 held, service_done after each grant -> grant order ch0, ch1, ch2, ch3, ch0; pointer after the ch3 service = 0.
- Mask and polarity: dreq_low = 1, DREQ = 4'b1110 (only ch0 active), mask = 4'b0001 -> no hrq; clearing the mask -> ch0 granted; dack_high = 0 -> DACK = 4'b1110 during dack_window.
- EOP abort: EOP_N driven low in SERVE -> RELEASE next cycle; hrq = 0 and VALID_DREQ = 0 one cycle later.
- Reset mid-SERVE: RESET_N = 0 for 1 cycle with ch2 locked -> next cycle hrq = 0, VALID_DREQ = 0, active_ch = 0, pointer = 0.
- DMA_SW_REQUEST_EN: mask = 4'b1111, sw_req = 4'b0100 -> ch2 granted; sw_req_clr = 4'b0100 for one cycle in RELEASE.

Source files
------------

// File: rtl/dma_priority_arbiter_if.sv
// Request/acknowledge bundle between the DMA channel arbiter (slave) and the command/timing side (master).
// The software-request lines exist only when DMA_SW_REQUEST_EN is defined.
interface dma_priority_arbiter_if #(
    parameter int NCH = 4
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] DREQ;
    logic [NCH-1:0] mask;
    logic           ctrl_disable;
    logic           rotate_en;
    logic           dreq_low;
    logic           dack_high;
    logic           HLDA;
    logic           dack_window;
    logic           service_done;
    logic           EOP_N;

    logic [NCH-1:0] VALID_DREQ;
    logic [NCH-1:0] DACK;
    logic           hrq;
    logic [CHW-1:0] active_ch;
    logic           busy;

`ifdef DMA_SW_REQUEST_EN
    logic [NCH-1:0] sw_req;
    logic [NCH-1:0] sw_req_clr;

    modport master (
        output DREQ, mask, ctrl_disable, rotate_en, dreq_low, dack_high,
               HLDA, dack_window, service_done, EOP_N, sw_req,
        input  VALID_DREQ, DACK, hrq, active_ch, busy, sw_req_clr
    );

    modport slave (
        input  DREQ, mask, ctrl_disable, rotate_en, dreq_low, dack_high,
               HLDA, dack_window, service_done, EOP_N, sw_req,
        output VALID_DREQ, DACK, hrq, active_ch, busy, sw_req_clr
    );
`else
    modport master (
        output DREQ, mask, ctrl_disable, rotate_en, dreq_low, dack_high,
               HLDA, dack_window, service_done, EOP_N,
        input  VALID_DREQ, DACK, hrq, active_ch, busy
    );

    modport slave (
        input  DREQ, mask, ctrl_disable, rotate_en, dreq_low, dack_high,
               HLDA, dack_window, service_done, EOP_N,
        output VALID_DREQ, DACK, hrq, active_ch, busy
    );
`endif
endinterface

// File: rtl/dma_priority_arbiter.sv
// 8237A-style DMA channel priority resolver: syncs DREQ, locks one winner per service, drives HRQ/DACK.
// Optional unmaskable software requests are enabled with the DMA_SW_REQUEST_EN macro.
module dma_priority_arbiter #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 1
) (
    input logic                   CLK,
    input logic                   RESET_N,
    dma_priority_arbiter_if.slave bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        ARB     = 5'b00010,
        HOLD    = 5'b00100,
        SERVE   = 5'b01000,
        RELEASE = 5'b10000
    } state_t;

    state_t         state;
    state_t         stateNext;

    logic [NCH-1:0] reqSync_p0;
    logic [NCH-1:0] reqSync_p1;
    logic [NCH-1:0] reqS;
    logic [NCH-1:0] eligible;
    logic           anyEligible;

    logic [CHW-1:0] prioPtr;
    logic [CHW-1:0] searchBase;
    logic [CHW-1:0] winner;

    logic [NCH-1:0] validDreq;
    logic [CHW-1:0] activeCh;
    logic           busyR;
    logic [NCH-1:0] dackAct;

    // Circular search: first set bit of req at or after base, wrapping past NCH-1.
    function automatic logic [CHW-1:0] pickWinner(input logic [NCH-1:0] req,
                                                  input logic [CHW-1:0] base);
        logic [CHW-1:0] idx;
        logic           found;
        pickWinner = base;
        found      = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = CHW'((int'(base) + i) % NCH);
            if (!found && req[idx]) begin
                pickWinner = idx;
                found      = 1'b1;
            end
        end
    endfunction

    // Stage p0/p1: request synchronisers with polarity normalised to active-high.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            reqSync_p0 <= '0;
            reqSync_p1 <= '0;
        end else begin
            reqSync_p0 <= bus.DREQ ^ {NCH{bus.dreq_low}};
            reqSync_p1 <= reqSync_p0;
        end
    end

    assign reqS = (SYNC_STAGES >= 2) ? reqSync_p1 : reqSync_p0;

`ifdef DMA_SW_REQUEST_EN
    logic swServ;

    // Software requests bypass the mask.
    assign eligible = (reqS | bus.sw_req) & ~(bus.mask & ~bus.sw_req);
`else
    assign eligible = reqS & ~bus.mask;
`endif

    assign anyEligible = (eligible != '0);
    assign searchBase  = bus.rotate_en ? prioPtr : '0;
    assign winner      = pickWinner(eligible, searchBase);

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (anyEligible && !bus.ctrl_disable) stateNext = ARB;
            ARB:     stateNext = anyEligible ? HOLD : IDLE;
            HOLD:    if (bus.HLDA) stateNext = SERVE;
            SERVE:   if (bus.service_done || !bus.EOP_N) stateNext = RELEASE;
            RELEASE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= IDLE;
            validDreq <= '0;
            activeCh  <= '0;
            busyR     <= 1'b0;
            prioPtr   <= '0;
`ifdef DMA_SW_REQUEST_EN
            swServ    <= 1'b0;
`endif
        end else begin
            state <= stateNext;
            if (state == ARB && anyEligible) begin
                validDreq <= NCH'(1) << winner;
                activeCh  <= winner;
                busyR     <= 1'b1;
`ifdef DMA_SW_REQUEST_EN
                swServ    <= bus.sw_req[winner];
`endif
            end else if (state == SERVE && stateNext == RELEASE) begin
                validDreq <= '0;
                busyR     <= 1'b0;
            end
            // Rotating mode makes the just-serviced channel the lowest priority.
            if (state == RELEASE) begin
                prioPtr <= bus.rotate_en ? CHW'((int'(activeCh) + 1) % NCH) : '0;
            end
        end
    end

    assign dackAct = (RESET_N && state == SERVE && bus.HLDA && bus.dack_window) ? validDreq : '0;

    assign bus.DACK       = dackAct ^ {NCH{~bus.dack_high}};
    assign bus.VALID_DREQ = validDreq;
    assign bus.hrq        = (state == HOLD) || (state == SERVE);
    assign bus.active_ch  = activeCh;
    assign bus.busy       = busyR;

`ifdef DMA_SW_REQUEST_EN
    assign bus.sw_req_clr = (state == RELEASE && swServ) ? (NCH'(1) << activeCh) : '0;
`endif

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: vector table of single grants plus hand-written multi-cycle sequences.
// Expected grants are queued when requests are driven and popped when the arbiter raises hrq.
module tb_dma_priority_arbiter;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rstN;

    always #5 clk = ~clk;

    dma_priority_arbiter_if #(.NCH(NCH)) bus ();

    dma_priority_arbiter #(.NCH(NCH), .SYNC_STAGES(1)) dut (
        .CLK     (clk),
        .RESET_N (rstN),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [3:0] dreq;
        logic [3:0] mask;
        logic       dreqLow;
        logic       dackHigh;
        logic       ctrlDis;
        logic [3:0] expGrant;
        logic [3:0] expDack;
    } vec_t;

    vec_t       vecs[9];
    logic [3:0] sbq[$];
    int         nChecks = 0;
    int         nFail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] idxOf(input logic [3:0] oh);
        idxOf = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) idxOf = 2'(i);
    endfunction

    task automatic waitHrq(input int limit, output int cyc);
        cyc = 0;
        while (cyc < limit) begin
            tick();
            cyc++;
            if (bus.hrq) break;
        end
    endtask

    task automatic grantCheck(input string name, input int limit, output int cyc);
        logic [3:0] exp;
        waitHrq(limit, cyc);
        check({name, " hrq"}, 32'(bus.hrq), 32'd1);
        if (sbq.size() == 0) begin
            nChecks++;
            nFail++;
            $display("FAIL %s scoreboard: grant 0x%0h with nothing queued", name, bus.VALID_DREQ);
        end else begin
            exp = sbq.pop_front();
            check({name, " VALID_DREQ"}, 32'(bus.VALID_DREQ), 32'(exp));
            check({name, " active_ch"}, 32'(bus.active_ch), 32'(idxOf(exp)));
            check({name, " busy"}, 32'(bus.busy), 32'd1);
        end
    endtask

    task automatic quickServe(input string name);
        bus.HLDA = 1'b1;
        tick();
        bus.service_done = 1'b1;
        tick();
        bus.service_done = 1'b0;
        bus.HLDA = 1'b0;
        check({name, " release hrq"}, 32'(bus.hrq), 32'd0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vec_t v;

        vecs[0] = '{4'b1010, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b0010};
        vecs[1] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0001};
        vecs[2] = '{4'b1100, 4'b0100, 1'b0, 1'b1, 1'b0, 4'b1000, 4'b1000};
        vecs[3] = '{4'b1110, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000};
        vecs[4] = '{4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b1110};
        vecs[5] = '{4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b1101};
        vecs[6] = '{4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000};
        vecs[7] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000};
        vecs[8] = '{4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1000, 4'b1000};

        bus.DREQ = '0; bus.mask = '0; bus.ctrl_disable = 1'b0; bus.rotate_en = 1'b0;
        bus.dreq_low = 1'b0; bus.dack_high = 1'b1; bus.HLDA = 1'b0; bus.dack_window = 1'b0;
        bus.service_done = 1'b0; bus.EOP_N = 1'b1;
`ifdef DMA_SW_REQUEST_EN
        bus.sw_req = '0;
`endif
        rstN = 1'b0;
        tick();
        tick();
        check("reset hrq", 32'(bus.hrq), 32'd0);
        check("reset VALID_DREQ", 32'(bus.VALID_DREQ), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset active_ch", 32'(bus.active_ch), 32'd0);
        check("reset DACK", 32'(bus.DACK), 32'd0);
        rstN = 1'b1;
        tick();

        for (int k = 0; k < 9; k++) begin
            v = vecs[k];
            bus.dreq_low = v.dreqLow;
            bus.dack_high = v.dackHigh;
            bus.mask = v.mask;
            bus.ctrl_disable = v.ctrlDis;
            bus.DREQ = v.dreq;
            if (v.expGrant != 4'b0000) sbq.push_back(v.expGrant);
            if (v.expGrant == 4'b0000) begin
                waitHrq(6, cyc);
                check($sformatf("vec%0d no-grant hrq", k), 32'(bus.hrq), 32'd0);
                bus.DREQ = {4{v.dreqLow}};
                tick();
                tick();
                bus.ctrl_disable = 1'b0;
            end else begin
                grantCheck($sformatf("vec%0d", k), 6, cyc);
                check($sformatf("vec%0d latency", k), 32'(cyc), 32'd3);
                bus.DREQ = {4{v.dreqLow}};
                bus.HLDA = 1'b1;
                tick();
                check($sformatf("vec%0d DACK idle", k), 32'(bus.DACK), 32'({4{~v.dackHigh}}));
                bus.dack_window = 1'b1;
                #1;
                check($sformatf("vec%0d DACK", k), 32'(bus.DACK), 32'(v.expDack));
                bus.dack_window = 1'b0;
                bus.service_done = 1'b1;
                tick();
                bus.service_done = 1'b0;
                check($sformatf("vec%0d rel hrq", k), 32'(bus.hrq), 32'd0);
                check($sformatf("vec%0d rel VALID_DREQ", k), 32'(bus.VALID_DREQ), 32'd0);
                check($sformatf("vec%0d rel busy", k), 32'(bus.busy), 32'd0);
                check($sformatf("vec%0d rel DACK", k), 32'(bus.DACK), 32'({4{~v.dackHigh}}));
                bus.HLDA = 1'b0;
                tick();
            end
        end

        // Locked grant survives a higher-priority request; HLDA low in SERVE; EOP abort.
        bus.dreq_low = 1'b0; bus.dack_high = 1'b1; bus.mask = '0;
        bus.DREQ = 4'b0010;
        sbq.push_back(4'b0010);
        grantCheck("eop", 6, cyc);
        bus.DREQ = 4'b0001;
        tick();
        tick();
        check("hold lock VALID_DREQ", 32'(bus.VALID_DREQ), 32'b0010);
        bus.DREQ = 4'b0000;
        bus.HLDA = 1'b1;
        tick();
        bus.HLDA = 1'b0;
        bus.dack_window = 1'b1;
        #1;
        check("hlda-low DACK", 32'(bus.DACK), 32'd0);
        tick();
        check("hlda-low hrq", 32'(bus.hrq), 32'd1);
        bus.HLDA = 1'b1;
        #1;
        check("eop DACK", 32'(bus.DACK), 32'b0010);
        bus.EOP_N = 1'b0;
        tick();
        bus.EOP_N = 1'b1;
        bus.dack_window = 1'b0;
        bus.HLDA = 1'b0;
        check("eop hrq", 32'(bus.hrq), 32'd0);
        check("eop VALID_DREQ", 32'(bus.VALID_DREQ), 32'd0);
        check("eop busy", 32'(bus.busy), 32'd0);
        tick();

        // service_done and EOP together count as one completion.
        bus.DREQ = 4'b0100;
        sbq.push_back(4'b0100);
        grantCheck("dual", 6, cyc);
        bus.DREQ = 4'b0000;
        bus.HLDA = 1'b1;
        tick();
        bus.service_done = 1'b1;
        bus.EOP_N = 1'b0;
        tick();
        bus.service_done = 1'b0;
        bus.EOP_N = 1'b1;
        bus.HLDA = 1'b0;
        check("dual rel hrq", 32'(bus.hrq), 32'd0);
        tick();
        tick();
        check("dual idle hrq", 32'(bus.hrq), 32'd0);
        check("dual idle busy", 32'(bus.busy), 32'd0);

        // Rotating priority with all requests held.
        bus.rotate_en = 1'b1;
        bus.DREQ = 4'b1111;
        sbq.push_back(4'b0001); sbq.push_back(4'b0010); sbq.push_back(4'b0100);
        sbq.push_back(4'b1000); sbq.push_back(4'b0001);
        for (int i = 0; i < 5; i++) begin
            grantCheck($sformatf("rot%0d", i), 8, cyc);
            if (i == 4) bus.DREQ = 4'b0000;
            bus.HLDA = 1'b1;
            tick();
            bus.service_done = 1'b1;
            tick();
            bus.service_done = 1'b0;
            bus.HLDA = 1'b0;
            check($sformatf("rot%0d rel hrq", i), 32'(bus.hrq), 32'd0);
        end
        tick();

        // Reset mid-SERVE with ch2 locked; pointer returns to ch0.
        bus.DREQ = 4'b0100;
        sbq.push_back(4'b0100);
        grantCheck("rstmid", 6, cyc);
        bus.HLDA = 1'b1;
        tick();
        bus.dack_window = 1'b1;
        rstN = 1'b0;
        tick();
        check("rstmid hrq", 32'(bus.hrq), 32'd0);
        check("rstmid VALID_DREQ", 32'(bus.VALID_DREQ), 32'd0);
        check("rstmid active_ch", 32'(bus.active_ch), 32'd0);
        check("rstmid busy", 32'(bus.busy), 32'd0);
        check("rstmid DACK", 32'(bus.DACK), 32'd0);
        rstN = 1'b1;
        bus.HLDA = 1'b0;
        bus.dack_window = 1'b0;
        bus.DREQ = 4'b0000;
        tick();
        bus.DREQ = 4'b1111;
        sbq.push_back(4'b0001);
        grantCheck("rstptr", 6, cyc);
        bus.DREQ = 4'b0000;
        quickServe("rstptr");

        // Rotating pointer now at ch1; switching to fixed mode restores ch0 as highest.
        bus.rotate_en = 1'b0;
        bus.DREQ = 4'b1111;
        sbq.push_back(4'b0001);
        grantCheck("fixback", 6, cyc);
        bus.DREQ = 4'b0000;
        quickServe("fixback");

`ifdef DMA_SW_REQUEST_EN
        bus.mask = 4'b1111;
        bus.sw_req = 4'b0100;
        sbq.push_back(4'b0100);
        grantCheck("swreq", 6, cyc);
        bus.HLDA = 1'b1;
        tick();
        bus.service_done = 1'b1;
        bus.sw_req = 4'b0000;
        tick();
        bus.service_done = 1'b0;
        bus.HLDA = 1'b0;
        check("swreq clr", 32'(bus.sw_req_clr), 32'b0100);
        tick();
        check("swreq clr pulse", 32'(bus.sw_req_clr), 32'd0);
        bus.mask = 4'b0000;
        tick();
`endif

        check("scoreboard drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
